mbgd_weight_update: RTL and testbench
=====================================

# mbgd_weight_update

Write-back stage of the mini-batch gradient descent datapath, and the broadcast counterpart of the dot-product reduction adder. It accepts one reduced gradient sum together with the N-element feature row that produced it. It then updates the N stored weights sequentially through a single shared multiplier, one weight per cycle: w[i] -= (grad * x[i]) >>> LR_SHIFT. The weight bank output feeds the dot-product stage for the next batch.

## Interface
- N, 8, number of weights / features in a row
- N_bit, 3, log2(N); growth bits of the reduced sum
- DW, 8, bits per weight and per feature (signed)
- LR_SHIFT, 4, learning rate as a right-shift amount (lr = 2^-LR_SHIFT)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- grad_valid  in  1  gradient offer
- grad_ready  out  1  block can accept a gradient (IDLE only)
- grad  in  2*DW+N_bit  signed reduced gradient sum
- x_vec  in  N*DW  feature row, element i at bits [i*DW +: DW], signed
- w_load  in  1  load weight bank from w_load_data (IDLE only)
- w_load_data  in  N*DW  initial weights, same packing as x_vec
- weights  out  N*DW  current weight bank, same packing
- busy  out  1  update sequence in progress
- update_done  out  1  one-cycle pulse after the last weight is written
- sat_seen  out  1  sticky saturation flag (see Configuration)

## Operation
- All outputs reset to 0. The reset state is IDLE, with grad_ready=1 once reset deasserts.
- FSM states:
  - IDLE: grad_ready=1. If grad_valid, capture grad and x_vec into internal registers, set idx=0, go to UPDATE. Otherwise, if w_load, write weights <= w_load_data and clear sat_seen. If both are high, the gradient wins and w_load is ignored.
  - UPDATE: busy=1, grad_ready=0. On each edge, write weights[idx] and increment idx. When idx==N-1 is written, go to DONE. grad_valid and w_load are ignored.
  - DONE: update_done=1 for exactly one cycle, busy=0, grad_ready=0, then go to IDLE.
- Arithmetic is signed two's complement throughout:
  - prod = grad * x[idx], width 3*DW+N_bit.
  - delta = prod >>> LR_SHIFT (arithmetic shift, truncates toward −inf).
  - wide = w[idx] − delta, computed at width 3*DW+N_bit+1 with no overflow.
  - wide is reduced to DW bits per Configuration.
- The captured grad and x_vec are stable for the whole sequence. Changes on the inputs after the handshake have no effect.
- idx counts 0..N-1 and never wraps inside a sequence. It resets to 0 on each accept.

## Timing
- Call the accept edge E0 (grad_valid && grad_ready).
- weights[i] is updated at edge E0+1+i.
- busy is high for cycles E0..E0+N-1.
- update_done is high in the cycle after edge E0+N.
- grad_ready returns high after edge E0+N+1.
- Throughput: one gradient per N+2 cycles. With grad_valid held high continuously, back-to-back gradients are accepted every N+2 cycles.
- w_load takes effect one edge after it is sampled in IDLE.
- Asserting reset mid-sequence immediately clears weights, idx, the FSM and all flags. No partial result is retained.

## Configuration
- Macro MBGD_WEIGHT_SAT_EN controls how wide is reduced to DW bits.
- Defined:
  - wide is clamped to [−2^(DW−1), 2^(DW−1)−1].
  - Any clamp sets sat_seen.
  - sat_seen stays set until reset or w_load.
- Undefined:
  - wide is truncated to its low DW bits (wrap-around).
  - sat_seen is tied to 0.

## Test plan
- Reset: assert reset low mid-run -> weights=0, busy=0, update_done=0, sat_seen=0, grad_ready=1 after release.
- Basic update: load all weights = 10, grad = 2, all x = 8 -> prod=16, delta=1, all weights = 9; update_done exactly once, at cycle E0+N+1.
- Negative gradient: weights = 10, grad = −32, x[i] = i -> delta = −2i, weights[i] = 10+2i (10, 12, …, 24). Verify the per-element write order at edges E0+1..E0+8.
- Saturation: weights = 120, grad = −1024, all x = 16 -> delta = −1024.
  - With MBGD_WEIGHT_SAT_EN: all weights = 127, sat_seen=1. A subsequent w_load clears sat_seen.
  - Without MBGD_WEIGHT_SAT_EN: 1144 wraps to 120, sat_seen=0.
- Handshake: hold grad_valid high with two different gradients -> second accepted exactly N+2 cycles after the first. Pulse w_load during UPDATE -> ignored. Assert w_load together with grad_valid in IDLE -> gradient accepted and bank not loaded.
- Input stability: change grad and x_vec every cycle during UPDATE -> results match the values captured at E0.

Source files
------------

// File: rtl/mbgd_weight_update_if.sv
// Handshake and weight-bank bus of the gradient-descent write-back stage.
// Packing of x_vec / w_load_data / weights: element i at bits [i*DW +: DW].
interface mbgd_weight_update_if #(
    parameter int N     = 8,
    parameter int N_bit = 3,
    parameter int DW    = 8
);
    logic                    grad_valid;
    logic                    grad_ready;
    logic [2*DW+N_bit-1:0]   grad;
    logic [N*DW-1:0]         x_vec;
    logic                    w_load;
    logic [N*DW-1:0]         w_load_data;
    logic [N*DW-1:0]         weights;
    logic                    busy;
    logic                    update_done;
    logic                    sat_seen;

    modport master (
        output grad_valid, grad, x_vec, w_load, w_load_data,
        input  grad_ready, weights, busy, update_done, sat_seen
    );

    modport slave (
        input  grad_valid, grad, x_vec, w_load, w_load_data,
        output grad_ready, weights, busy, update_done, sat_seen
    );
endinterface

// File: rtl/mbgd_weight_update.sv
// Sequential weight write-back: w[i] -= (grad * x[i]) >>> LR_SHIFT, one weight per cycle.
// Define MBGD_WEIGHT_SAT_EN to clamp results and track sat_seen; otherwise results wrap.
module mbgd_weight_update #(
    parameter int N        = 8,
    parameter int N_bit    = 3,
    parameter int DW       = 8,
    parameter int LR_SHIFT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mbgd_weight_update_if.slave bus
);
    localparam int GW = 2*DW + N_bit;
    localparam int PW = 3*DW + N_bit;
    localparam int WW = PW + 1;
    localparam logic [N_bit-1:0] LAST = N_bit'(N - 1);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grad_q, grad_d;
    logic [N*DW-1:0]   x_q, x_d;
    logic [N*DW-1:0]   w_q, w_d;
    logic [N_bit-1:0]  idx_q, idx_d;

    logic [DW-1:0]         w_cur, x_cur, w_new;
    logic signed [PW-1:0]  grad_ext, x_ext, delta;
    logic signed [WW-1:0]  wide;

    always_comb begin
        w_cur    = w_q[idx_q*DW +: DW];
        x_cur    = x_q[idx_q*DW +: DW];
        grad_ext = {{(PW-GW){grad_q[GW-1]}}, grad_q};
        x_ext    = {{(PW-DW){x_cur[DW-1]}}, x_cur};
        delta    = (grad_ext * x_ext) >>> LR_SHIFT;
        // One extra bit keeps the subtraction exact for any operands.
        wide     = {{(WW-DW){w_cur[DW-1]}}, w_cur} - {delta[PW-1], delta};
    end

`ifdef MBGD_WEIGHT_SAT_EN
    logic clamp;
    logic sat_q, sat_d;

    always_comb begin
        clamp = wide[WW-1] ? !(&wide[WW-2:DW-1]) : (|wide[WW-2:DW-1]);
        if (!clamp)
            w_new = wide[DW-1:0];
        else if (wide[WW-1])
            w_new = {1'b1, {(DW-1){1'b0}}};
        else
            w_new = {1'b0, {(DW-1){1'b1}}};
    end

    always_comb begin
        sat_d = sat_q;
        if (state_q == IDLE && !bus.grad_valid && bus.w_load)
            sat_d = 1'b0;
        else if (state_q == UPDATE && clamp)
            sat_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sat_q <= 1'b0;
        else        sat_q <= sat_d;
    end

    assign bus.sat_seen = sat_q;
`else
    logic unused_wide_hi;

    assign w_new          = wide[DW-1:0];
    assign unused_wide_hi = ^wide[WW-1:DW];
    assign bus.sat_seen   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grad_d  = grad_q;
        x_d     = x_q;
        w_d     = w_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.grad_valid) begin
                    state_d = UPDATE;
                    grad_d  = bus.grad;
                    x_d     = bus.x_vec;
                    idx_d   = '0;
                end else if (bus.w_load) begin
                    w_d = bus.w_load_data;
                end
            end
            UPDATE: begin
                w_d[idx_q*DW +: DW] = w_new;
                if (idx_q == LAST) state_d = DONE;
                else               idx_d   = idx_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grad_q  <= '0;
            x_q     <= '0;
            w_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            grad_q  <= grad_d;
            x_q     <= x_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
        end
    end

    // grad_ready is gated by reset so every output reads 0 while reset is held.
    assign bus.grad_ready  = (state_q == IDLE) && reset;
    assign bus.busy        = (state_q == UPDATE);
    assign bus.update_done = (state_q == DONE);
    assign bus.weights     = w_q;
endmodule

// File: tb/tb_mbgd_weight_update.sv
// Directed scoreboard bench for mbgd_weight_update (wrap or clamp per MBGD_WEIGHT_SAT_EN).
module tb_mbgd_weight_update;
    localparam int N        = 8;
    localparam int N_bit    = 3;
    localparam int DW       = 8;
    localparam int LR_SHIFT = 4;
    localparam int GW       = 2*DW + N_bit;
    localparam int BW       = N*DW;

    typedef struct {
        logic [BW-1:0] w;
        logic          sat;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [BW-1:0] model_bank = '0;
    logic          model_sat  = 1'b0;

    mbgd_weight_update_if #(.N(N), .N_bit(N_bit), .DW(DW)) bus ();

    mbgd_weight_update #(.N(N), .N_bit(N_bit), .DW(DW), .LR_SHIFT(LR_SHIFT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] model_elem(input int w, input int g, input int x, output logic sat);
        longint wide;
        wide = longint'(w) - ((longint'(g) * longint'(x)) >>> LR_SHIFT);
        sat  = 1'b0;
`ifdef MBGD_WEIGHT_SAT_EN
        if (wide > (longint'(1) <<< (DW-1)) - 1) begin
            wide = (longint'(1) <<< (DW-1)) - 1;
            sat  = 1'b1;
        end else if (wide < -(longint'(1) <<< (DW-1))) begin
            wide = -(longint'(1) <<< (DW-1));
            sat  = 1'b1;
        end
`endif
        return wide[DW-1:0];
    endfunction

    function automatic logic [BW-1:0] fill(input logic [DW-1:0] v);
        return {N{v}};
    endfunction

    task automatic push_exp(input logic [GW-1:0] g, input logic [BW-1:0] xv);
        exp_t e;
        logic s;
        for (int i = 0; i < N; i++) begin
            model_bank[i*DW +: DW] = model_elem(int'($signed(model_bank[i*DW +: DW])),
                                                int'($signed(g)), int'($signed(xv[i*DW +: DW])), s);
            model_sat = model_sat | s;
        end
        e.w   = model_bank;
        e.sat = model_sat;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_sb_avail"}, BW'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_weights"}, bus.weights, e.w);
            chk({tag, "_sat"}, bus.sat_seen, e.sat);
        end
    endtask

    task automatic load_bank(input logic [BW-1:0] d, input string tag);
        bus.w_load      = 1'b1;
        bus.w_load_data = d;
        @(posedge clk); #1;
        bus.w_load = 1'b0;
        model_bank = d;
        model_sat  = 1'b0;
        chk({tag, "_w"}, bus.weights, d);
        chk({tag, "_sat"}, bus.sat_seen, 0);
    endtask

    task automatic run_grad(input string tag, input logic [GW-1:0] g, input logic [BW-1:0] xv,
                            input bit order, input bit scramble, input bit load_during,
                            input bit load_with, input logic [BW-1:0] ld_data);
        logic [BW-1:0] old_bank, new_bank;
        chk({tag, "_ready"}, bus.grad_ready, 1);
        old_bank = model_bank;
        push_exp(g, xv);
        new_bank = model_bank;
        bus.grad       = g;
        bus.x_vec      = xv;
        bus.grad_valid = 1'b1;
        if (load_with) begin
            bus.w_load      = 1'b1;
            bus.w_load_data = ld_data;
        end
        @(posedge clk); #1;
        bus.grad_valid = 1'b0;
        bus.w_load     = 1'b0;
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_notready"}, bus.grad_ready, 0);
        for (int i = 0; i < N; i++) begin
            if (scramble) begin
                bus.grad  = GW'($urandom);
                bus.x_vec = {$urandom, $urandom};
            end
            if (load_during) begin
                bus.w_load      = (i == 2 || i == 3);
                bus.w_load_data = ld_data;
            end
            @(posedge clk); #1;
            if (order) begin
                chk($sformatf("%s_w%0d_written", tag, i), bus.weights[i*DW +: DW], new_bank[i*DW +: DW]);
                if (i < N-1)
                    chk($sformatf("%s_w%0d_pending", tag, i+1), bus.weights[(i+1)*DW +: DW],
                        old_bank[(i+1)*DW +: DW]);
            end
            if (i < N-1) chk({tag, "_nodone"}, bus.update_done, 0);
        end
        bus.w_load = 1'b0;
        chk({tag, "_done"}, bus.update_done, 1);
        chk({tag, "_busy_low"}, bus.busy, 0);
        sb_check(tag);
        @(posedge clk); #1;
        chk({tag, "_done_once"}, bus.update_done, 0);
        chk({tag, "_ready_again"}, bus.grad_ready, 1);
    endtask

    initial begin
        logic [BW-1:0] xramp;
        int cyc;
        bit seen_idle, got;

        bus.grad_valid  = 1'b0;
        bus.grad        = '0;
        bus.x_vec       = '0;
        bus.w_load      = 1'b0;
        bus.w_load_data = '0;
        for (int i = 0; i < N; i++) xramp[i*DW +: DW] = DW'(i);

        repeat (2) @(posedge clk); #1;
        chk("rst_weights", bus.weights, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.update_done, 0);
        chk("rst_sat", bus.sat_seen, 0);
        chk("rst_ready", bus.grad_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready_release", bus.grad_ready, 1);

        load_bank(fill(8'd10), "load10");
        run_grad("basic", GW'(2), fill(8'd8), 1'b0, 1'b0, 1'b0, 1'b0, '0);

        load_bank(fill(8'd10), "load10b");
        run_grad("neg_grad", GW'(-32), xramp, 1'b1, 1'b0, 1'b0, 1'b0, '0);

        run_grad("stable_in", GW'(3), fill(8'hFB), 1'b0, 1'b1, 1'b0, 1'b0, '0);
        run_grad("wload_in_update", GW'(100), xramp, 1'b0, 1'b0, 1'b1, 1'b0, fill(8'h55));
        run_grad("wload_with_grad", GW'(-7), fill(8'd3), 1'b0, 1'b0, 1'b0, 1'b1, fill(8'h77));

        // Back-to-back: grad_valid held high across two different gradients.
        push_exp(GW'(5), xramp);
        bus.grad       = GW'(5);
        bus.x_vec      = xramp;
        bus.grad_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_first_busy", bus.busy, 1);
        push_exp(GW'(-9), fill(8'd7));
        bus.grad  = GW'(-9);
        bus.x_vec = fill(8'd7);
        cyc = 0; seen_idle = 0; got = 0;
        while (!got && cyc < 4*N) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.update_done) sb_check("b2b_first");
            if (!bus.busy) seen_idle = 1;
            else if (seen_idle) got = 1;
        end
        bus.grad_valid = 1'b0;
        chk("b2b_gap", BW'(cyc), N+2);
        cyc = 0;
        while (!bus.update_done && cyc < 4*N) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b_second_len", BW'(cyc), N);
        sb_check("b2b_second");
        @(posedge clk); #1;

        load_bank(fill(8'd120), "load120");
        run_grad("sat_pos", GW'(-1024), fill(8'd16), 1'b0, 1'b0, 1'b0, 1'b0, '0);
        load_bank(fill(8'd1), "sat_clear");
        load_bank(fill(8'h88), "load_m120");
        run_grad("sat_neg", GW'(1024), fill(8'd16), 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Reset asserted partway through an update sequence.
        push_exp(GW'(2), fill(8'd8));
        bus.grad       = GW'(2);
        bus.x_vec      = fill(8'd8);
        bus.grad_valid = 1'b1;
        @(posedge clk); #1;
        bus.grad_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_weights", bus.weights, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.update_done, 0);
        chk("midrst_sat", bus.sat_seen, 0);
        exp_q.delete();
        model_bank = '0;
        model_sat  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", bus.grad_ready, 1);
        chk("midrst_weights_after", bus.weights, 0);
        run_grad("after_rst", GW'(2), fill(8'd8), 1'b1, 1'b0, 1'b0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
